line_loader: RTL and testbench
==============================

Name: line_loader

Overview:
- Upstream stage of the line-permutation controller.
- Accepts 25-bit state lines from a valid/ready stream and writes them into the shared 64-entry line memory at consecutive addresses.
- When a full frame is in memory, it pulses start to the controller and stalls input until the controller reports done.
- It then re-arms for the next frame.

Parameters:
- LINE_W, 25, width of one memory line (5x5 slice).
- DEPTH, 64, lines per frame (memory entries).
- ADDR_W, 6, memory address width; must satisfy 2^ADDR_W >= DEPTH.
- START_CYCLES, 2, number of consecutive cycles start is held high.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset.
- in_valid  input  1  upstream line available.
- in_data  input  LINE_W  upstream line.
- in_ready  output  1  loader can accept a line this cycle.
- mem_wr  output  1  memory write strobe.
- mem_addr  output  ADDR_W  memory write address.
- mem_wdata  output  LINE_W  memory write data.
- start  output  1  frame-ready request to controller.
- done  input  1  controller finished the frame.
- busy  output  1  frame handed to controller, not yet done.
- lines_loaded  output  ADDR_W+1  lines written in the current frame, 0..DEPTH.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values, on the clk edge with rst=1, overriding everything else: state=LOAD, ptr=0, lines_loaded=0, mem_wr=0, mem_addr=0, mem_wdata=0, start=0, busy=0, start counter=0. in_ready=1 the cycle after reset.
- Reset mid-frame discards any partially loaded lines. No write is issued on the reset edge.
- A transfer occurs when in_valid & in_ready are high at a clk edge. in_data must be held stable by upstream while in_valid=1 and in_ready=0.
- FSM states: LOAD, FLUSH, KICK, RUN.
- LOAD: in_ready=1 combinationally.
  - On a transfer: register mem_wr=1, mem_addr=ptr, mem_wdata=in_data. The write is visible one cycle after acceptance.
  - On a transfer, also increment ptr and lines_loaded.
  - If the transfer has ptr=DEPTH-1, go to FLUSH and clear ptr to 0. ptr never exceeds DEPTH-1, with no wrap into the next frame.
  - Without a transfer, mem_wr=0 next cycle. mem_addr and mem_wdata hold their last values.
- FLUSH: in_ready=0. The last write completes this cycle (mem_wr=1). Next state is KICK.
- KICK: in_ready=0, mem_wr=0, start=1 for START_CYCLES cycles, counted by the start counter. Then go to RUN.
- RUN: in_ready=0, start=0, busy=1.
  - When done=1 is sampled: go to LOAD, busy=0 next cycle, lines_loaded=0.
- done is ignored in LOAD, FLUSH and KICK.
- Back-to-back transfers at one line per cycle are supported. A full frame needs DEPTH accepting cycles minimum. First start rise is 2 cycles after the last transfer.
- in_valid while in_ready=0 causes no state change and no write.
- lines_loaded reads DEPTH in FLUSH, KICK and RUN.

Decomposition:
- Shared package holds:
  - state encoding constants LOAD, FLUSH, KICK, RUN (2 bits);
  - LINE_W=25, DEPTH=64, ADDR_W=6, matching the controller's memory width and counter width.
- One sub-module, line_loader_ctr: a synchronous-clear up counter with enable and terminal-count flag. Instantiated twice: for ptr and for the start hold counter.

Test Plan:
- Reset, then 64 back-to-back lines with data=address+0x100 -> mem_wr high 64 consecutive cycles; addr 0..63 with matching data; start high exactly 2 cycles starting 2 cycles after the last transfer; busy=1 after.
- Random in_valid gaps (~50% duty) over 64 lines -> same memory contents, no duplicate or skipped address, lines_loaded steps 0..64.
- In RUN, hold in_valid=1 for 20 cycles, then done=1 -> in_ready=0, no writes until done. The next transfer writes addr 0.
- done=1 pulsed during LOAD (after 10 lines) and during KICK -> ignored; loading continues; start still 2 cycles.
- rst asserted after 37 lines -> next cycle lines_loaded=0, mem_wr=0, start=0. A new 64-line frame writes from addr 0.
- Two consecutive frames with done asserted in the first RUN cycle -> second frame accepted immediately, second start pulse produced, busy toggles correctly.

Source files
------------

// File: rtl/line_loader_pkg.sv
// rtl/line_loader_pkg.sv - shared constants and state encoding for the line loader
package line_loader_pkg;

    localparam int LINE_W       = 25;
    localparam int DEPTH        = 64;
    localparam int ADDR_W       = 6;
    localparam int START_CYCLES = 2;
    localparam int START_W      = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FLUSH = 2'd1,
        KICK  = 2'd2,
        RUN   = 2'd3
    } state_e;

endpackage

// File: rtl/line_loader_ctr.sv
// rtl/line_loader_ctr.sv - synchronous-clear up counter with enable and terminal-count flag
module line_loader_ctr #(
    parameter int WIDTH  = 6,
    parameter int TC_VAL = 63
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);

    localparam logic [WIDTH-1:0] TC = WIDTH'(TC_VAL);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Clear wins over enable so the terminal transfer lands the count back on zero.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == TC);

endmodule

// File: rtl/line_loader.sv
// rtl/line_loader.sv - streams one frame of lines into line memory and hands it to the controller
module line_loader
    import line_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [LINE_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    output logic              start,
    input  logic              done,
    output logic              busy,
    output logic [ADDR_W:0]   lines_loaded
);

    state_e              state_q, state_d;
    logic                mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                start_q, start_d;
    logic                busy_q, busy_d;
    logic [ADDR_W:0]     lines_q, lines_d;

    logic                xfer;
    logic [ADDR_W-1:0]   ptr;
    logic                ptr_tc;
    logic                kick_en;
    logic                kick_tc;
    logic [START_W-1:0]  kick_cnt_unused;

    assign in_ready = (state_q == LOAD);
    assign xfer     = in_valid & in_ready;
    assign kick_en  = (state_q == KICK);

    line_loader_ctr #(
        .WIDTH  (ADDR_W),
        .TC_VAL (DEPTH - 1)
    ) u_ptr_ctr (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (xfer & ptr_tc),
        .en_i    (xfer),
        .count_o (ptr),
        .tc_o    (ptr_tc)
    );

    line_loader_ctr #(
        .WIDTH  (START_W),
        .TC_VAL (START_CYCLES - 1)
    ) u_kick_ctr (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (kick_en & kick_tc),
        .en_i    (kick_en),
        .count_o (kick_cnt_unused),
        .tc_o    (kick_tc)
    );

    // Next state plus registered outputs; start and busy are derived from the next state
    // so they line up exactly with the KICK and RUN residency.
    always_comb begin
        state_d     = state_q;
        mem_wr_d    = xfer;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        lines_d     = lines_q;

        if (xfer) begin
            mem_addr_d  = ptr;
            mem_wdata_d = in_data;
            lines_d     = lines_q + (ADDR_W+1)'(1);
        end

        case (state_q)
            LOAD: begin
                if (xfer && ptr_tc) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d = KICK;
            end
            KICK: begin
                if (kick_tc) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (done) begin
                    state_d = LOAD;
                    lines_d = '0;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        start_d = (state_d == KICK);
        busy_d  = (state_d == RUN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            lines_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            lines_q     <= lines_d;
        end
    end

    assign mem_wr       = mem_wr_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign start        = start_q;
    assign busy         = busy_q;
    assign lines_loaded = lines_q;

endmodule

// File: tb/tb_line_loader.sv
// tb/tb_line_loader.sv - directed self-checking bench for line_loader
module tb_line_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [24:0] in_data = '0;
    logic        in_ready;
    logic        mem_wr;
    logic [5:0]  mem_addr;
    logic [24:0] mem_wdata;
    logic        start;
    logic        done = 1'b0;
    logic        busy;
    logic [6:0]  lines_loaded;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_xfer = 0;

    int wa_q[$];
    int wd_q[$];
    int wc_q[$];
    int st_q[$];

    line_loader dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .start        (start),
        .done         (done),
        .busy         (busy),
        .lines_loaded (lines_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (mem_wr) begin
            wa_q.push_back(int'(mem_addr));
            wd_q.push_back(int'(mem_wdata));
            wc_q.push_back(cyc);
        end
        if (start) st_q.push_back(cyc);
    endtask

    task automatic clear_logs();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        st_q.delete();
    endtask

    task automatic send_lines(input int base, input bit gaps, input int nlines, input int done_at);
        int sent = 0;
        int guard = 0;
        int lbad = 0;
        bit xfer;
        clear_logs();
        while (sent < nlines && guard < 1000) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = 25'(base + sent);
            done     = (done_at >= 0) && (sent == done_at);
            xfer     = in_valid && in_ready;
            step();
            if (xfer) begin
                sent++;
                last_xfer = cyc;
                if (int'(lines_loaded) != sent) lbad++;
            end
            guard++;
        end
        in_valid = 1'b0;
        done     = 1'b0;
        check("lines_sent", sent, nlines);
        check("lines_loaded_step", lbad, 0);
    endtask

    task automatic check_writes(input int base, input int n, input bit b2b);
        int bad = 0;
        check("wr_count", wa_q.size(), n);
        for (int i = 0; i < wa_q.size() && i < n; i++) begin
            if (wa_q[i] != i || wd_q[i] != base + i) bad++;
        end
        check("wr_content", bad, 0);
        if (b2b && wc_q.size() == n) check("wr_consecutive", wc_q[n-1] - wc_q[0], n - 1);
    endtask

    task automatic finish_frame(input bit done_in_kick);
        int guard = 0;
        while (!busy && guard < 10) begin
            done = done_in_kick && start;
            step();
            guard++;
        end
        done = 1'b0;
        check("busy_up", int'(busy), 1);
        check("busy_latency", cyc - last_xfer, 3);
        check("start_len", st_q.size(), 2);
        if (st_q.size() > 0) check("start_rise", st_q[0] - last_xfer, 1);
        check("lines_full", int'(lines_loaded), 64);
        check("ready_run", int'(in_ready), 0);
        check("wr_idle_run", int'(mem_wr), 0);
    endtask

    task automatic release_frame();
        done = 1'b1;
        step();
        done = 1'b0;
        check("busy_down", int'(busy), 0);
        check("ready_rearm", int'(in_ready), 1);
        check("lines_clear", int'(lines_loaded), 0);
    endtask

    initial begin
        int wr_before;
        int rbad;

        // reset with upstream already presenting data: nothing may be written
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 25'h1abcd;
        repeat (3) step();
        rst = 1'b0;
        in_valid = 1'b0;
        check("rst_ready", int'(in_ready), 1);
        check("rst_wr", int'(mem_wr), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_wdata", int'(mem_wdata), 0);
        check("rst_start", int'(start), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_lines", int'(lines_loaded), 0);

        // back-to-back frame
        send_lines(32'h100, 1'b0, 64, -1);
        check_writes(32'h100, 64, 1'b1);
        finish_frame(1'b0);

        // upstream pushes during RUN: stalled, no writes
        wr_before = wa_q.size();
        rbad = 0;
        in_valid = 1'b1;
        in_data = 25'h0dead;
        for (int i = 0; i < 20; i++) begin
            step();
            if (in_ready) rbad++;
        end
        in_valid = 1'b0;
        check("run_stall_ready", rbad, 0);
        check("run_stall_wr", wa_q.size() - wr_before, 0);
        check("run_busy_hold", int'(busy), 1);
        release_frame();

        // gapped frame restarts at address 0
        send_lines(32'h200, 1'b1, 64, -1);
        check_writes(32'h200, 64, 1'b0);
        finish_frame(1'b0);
        release_frame();

        // done pulsed in LOAD after 10 lines and again in KICK
        send_lines(32'h280, 1'b0, 64, 10);
        check_writes(32'h280, 64, 1'b1);
        finish_frame(1'b1);
        release_frame();

        // reset mid-frame
        send_lines(32'h300, 1'b0, 37, -1);
        check_writes(32'h300, 37, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_lines", int'(lines_loaded), 0);
        check("midrst_wr", int'(mem_wr), 0);
        check("midrst_start", int'(start), 0);
        check("midrst_ready", int'(in_ready), 1);
        send_lines(32'h400, 1'b1, 64, -1);
        check_writes(32'h400, 64, 1'b0);
        finish_frame(1'b0);
        release_frame();

        // two frames, done in the first RUN cycle
        send_lines(32'h500, 1'b0, 64, -1);
        check_writes(32'h500, 64, 1'b1);
        finish_frame(1'b0);
        release_frame();
        send_lines(32'h600, 1'b0, 64, -1);
        check_writes(32'h600, 64, 1'b1);
        finish_frame(1'b0);
        release_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
